ysyx_24080014_fetch_seq: RTL

Fetch sequencer for the ysyx_24080014 NPC core. It owns the architectural PC register and issues instruction fetches to instruction memory over a valid/ready handshake. It hands each fetched instruction to decode and waits for writeback to report retirement. At retirement it loads the next-PC value produced by the jump unit. It also detects halt, fetch errors, fetch timeouts and misaligned targets, and stops fetching when any of them occurs.

---
 rtl/ysyx_24080014_fetch_seq_if.sv | 36 +++
 rtl/ysyx_24080014_fetch_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/ysyx_24080014_fetch_seq_if.sv
// Fetch sequencer bus bundle: instruction-memory handshake, decode hand-off,
// writeback feedback and status. The sequencer drives the master side.
interface ysyx_24080014_fetch_seq_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        wb_done;
  logic [31:0] next_pc;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] retire_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc,
           halted, fault, fault_cause, fault_addr, retire_cnt,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, wb_done, next_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc,
           halted, fault, fault_cause, fault_addr, retire_cnt,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, wb_done, next_pc, halt
  );
endinterface

// File: rtl/ysyx_24080014_fetch_seq.sv
// Fetch sequencer: owns the PC, fetches over a valid/ready bus, hands the
// instruction to decode, and advances on retirement until halt or fault.
module ysyx_24080014_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_24080014_fetch_seq_if.master     bus
);

  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_BUS   = 2'd1;
  localparam logic [1:0] CAUSE_TMO   = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_ISSUE,
    S_EXECUTE,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        inst_q;
  logic [31:0]        retire_cnt_q;
  logic [1:0]         fault_cause_q;
  logic [31:0]        fault_addr_q;
  logic [TIMER_W-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH_REQ;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      retire_cnt_q  <= '0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
      timer_q       <= '0;
    end else begin
      case (state_q)
        S_FETCH_REQ: begin
          if (bus.imem_req_ready) begin
            state_q <= S_FETCH_WAIT;
            timer_q <= '0;
          end
        end
        // A response in the timeout cycle takes priority over the timeout.
        S_FETCH_WAIT: begin
          timer_q <= timer_q + TIMER_W'(1);
          if (bus.imem_resp_valid) begin
            if (bus.imem_resp_err) begin
              state_q       <= S_FAULT;
              fault_cause_q <= CAUSE_BUS;
              fault_addr_q  <= pc_q;
            end else begin
              inst_q  <= bus.imem_resp_data;
              state_q <= S_ISSUE;
            end
          end else if (timer_q == TIMER_LAST) begin
            state_q       <= S_FAULT;
            fault_cause_q <= CAUSE_TMO;
            fault_addr_q  <= pc_q;
          end
        end
        S_ISSUE: begin
          if (bus.inst_ready) begin
            state_q <= S_EXECUTE;
          end
        end
        // Halt outranks a misaligned target on the same retirement.
        S_EXECUTE: begin
          if (bus.wb_done) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
            if (bus.halt) begin
              state_q <= S_HALTED;
            end else if (bus.next_pc[1:0] != 2'b00) begin
              state_q       <= S_FAULT;
              fault_cause_q <= CAUSE_ALIGN;
              fault_addr_q  <= bus.next_pc;
            end else begin
              pc_q    <= bus.next_pc;
              state_q <= S_FETCH_REQ;
            end
          end
        end
        S_HALTED, S_FAULT: ;
        default: state_q <= S_FETCH_REQ;
      endcase
    end
  end

  // Request valid is forced low while reset is held.
  assign bus.imem_req_valid = (state_q == S_FETCH_REQ) && !rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_ISSUE);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.halted         = (state_q == S_HALTED);
  assign bus.fault          = (state_q == S_FAULT);
  assign bus.fault_cause    = fault_cause_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.retire_cnt     = retire_cnt_q;

endmodule
